// File: rtl/life_grid_engine.sv
// 8x8 Game-of-Life engine: row-wise seed loading, single-edge whole-grid steps,
// generation counting and stable/extinct detection with automatic halt.
module life_grid_engine #(
    parameter int unsigned GEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [2:0]       load_row,
    input  logic [7:0]       load_data,
    input  logic             start,
    input  logic             pause,
    input  logic             step_tick,
    input  logic             wrap_en,
    output logic [63:0]      grid,
    output logic [1:0]       state,
    output logic [GEN_W-1:0] generation,
    output logic             stable,
    output logic             extinct
);

    localparam int unsigned CELLS = 64;
    localparam int unsigned SIDE  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BAD  = 2'b01,
        ST_RUN  = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [CELLS-1:0]   grid_q, grid_d, next_grid;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic               stable_q, stable_d;
    logic               extinct_q, extinct_d;

    // Cell lookup with either toroidal wrap or dead cells beyond the border.
    function automatic logic cell_at(input logic [CELLS-1:0] g, input int r, input int c,
                                     input logic wrap);
        int rr;
        int cc;
        rr = (r + int'(SIDE)) % int'(SIDE);
        cc = (c + int'(SIDE)) % int'(SIDE);
        if (!wrap && (r < 0 || r >= int'(SIDE) || c < 0 || c >= int'(SIDE)))
            return 1'b0;
        return g[6'(8 * rr + cc)];
    endfunction

    // Full-grid next generation from the registered grid.
    always_comb begin
        logic [3:0] cnt;
        logic       alive;
        next_grid = '0;
        cnt       = '0;
        alive     = 1'b0;
        for (int r = 0; r < int'(SIDE); r++) begin
            for (int c = 0; c < int'(SIDE); c++) begin
                cnt = '0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0)
                            cnt = cnt + {3'b000, cell_at(grid_q, r + dr, c + dc, wrap_en)};
                    end
                end
                alive = grid_q[6'(8 * r + c)];
                next_grid[6'(8 * r + c)] = (alive && (cnt == 4'd2 || cnt == 4'd3)) ||
                                           (!alive && cnt == 4'd3);
            end
        end
    end

    assign load_ready = (state_q == ST_IDLE) || (state_q == ST_HALT);

    // Next-state and register-input logic.
    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        gen_d     = gen_q;
        stable_d  = stable_q;
        extinct_d = extinct_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (load_valid)
                    grid_d[{load_row, 3'b000} +: 8] = load_data;
                if (start) begin
                    state_d   = ST_RUN;
                    gen_d     = '0;
                    stable_d  = 1'b0;
                    extinct_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (step_tick && !pause) begin
                    grid_d    = next_grid;
                    gen_d     = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
                    stable_d  = (next_grid == grid_q);
                    extinct_d = (next_grid == '0);
                    if (stable_d || extinct_d)
                        state_d = ST_HALT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            grid_q    <= '0;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            gen_q     <= gen_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
        end
    end

    assign grid       = grid_q;
    assign state      = state_q;
    assign generation = gen_q;
    assign stable     = stable_q;
    assign extinct    = extinct_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: known patterns with hand-derived grids.
module tb_life_grid_engine;

    logic        clk;
    logic        reset_n;
    logic        load_valid;
    logic        load_ready;
    logic [2:0]  load_row;
    logic [7:0]  load_data;
    logic        start;
    logic        pause;
    logic        step_tick;
    logic        wrap_en;
    logic [63:0] grid;
    logic [1:0]  state;
    logic [7:0]  generation;
    logic        stable;
    logic        extinct;

    int total = 0;
    int bad   = 0;

    life_grid_engine #(.GEN_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_row   (load_row),
        .load_data  (load_data),
        .start      (start),
        .pause      (pause),
        .step_tick  (step_tick),
        .wrap_en    (wrap_en),
        .grid       (grid),
        .state      (state),
        .generation (generation),
        .stable     (stable),
        .extinct    (extinct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] row, input logic [7:0] data);
        load_valid = 1'b1;
        load_row   = row;
        load_data  = data;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic step();
        step_tick = 1'b1;
        tick();
        step_tick = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b1;
        load_row   = 3'd2;
        load_data  = 8'hFF;
        start      = 1'b1;
        pause      = 1'b0;
        step_tick  = 1'b1;
        wrap_en    = 1'b0;

        // Inputs active while held in reset must not matter.
        #22;
        check("rst_grid", grid, 64'h0);
        check("rst_state", state, 2'b00);
        check("rst_gen", generation, 8'd0);
        check("rst_ready", load_ready, 1'b1);
        check("rst_flags", {stable, extinct}, 2'b00);
        load_valid = 1'b0;
        start      = 1'b0;
        step_tick  = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        check("post_rst_state", state, 2'b00);

        // Blinker.
        load(3'd3, 8'h1C);
        check("blk_load", grid, 64'h00000000_1C000000);
        do_start();
        check("blk_run", state, 2'b10);
        check("blk_ready_run", load_ready, 1'b0);
        step();
        check("blk_s1_grid", grid, 64'h00000008_08080000);
        check("blk_s1_gen", generation, 8'd1);
        step();
        check("blk_s2_grid", grid, 64'h00000000_1C000000);
        check("blk_s2_gen", generation, 8'd2);
        check("blk_s2_flags", {stable, extinct}, 2'b00);
        check("blk_s2_state", state, 2'b10);

        // Load while running is ignored.
        load(3'd5, 8'hFF);
        check("run_load_grid", grid, 64'h00000000_1C000000);

        // Paused ticks and start in RUN change nothing.
        pause = 1'b1;
        for (int i = 0; i < 3; i++) step();
        pause = 1'b0;
        check("pause_grid", grid, 64'h00000000_1C000000);
        check("pause_gen", generation, 8'd2);
        do_start();
        check("run_start_gen", generation, 8'd2);

        // Asynchronous reset mid-run, sampled between edges.
        reset_n = 1'b0;
        #1;
        check("async_grid", grid, 64'h0);
        check("async_state", state, 2'b00);
        check("async_gen", generation, 8'd0);
        check("async_ready", load_ready, 1'b1);
        reset_n = 1'b1;
        tick();
        check("after_abort_state", state, 2'b00);

        // Block still life.
        load(3'd1, 8'h06);
        load(3'd2, 8'h06);
        do_start();
        step();
        check("block_grid", grid, 64'h00000000_00060600);
        check("block_flags", {stable, extinct}, 2'b10);
        check("block_state", state, 2'b11);
        check("block_gen", generation, 8'd1);
        check("halt_ready", load_ready, 1'b1);
        step();
        check("halt_hold_gen", generation, 8'd1);
        load(3'd7, 8'h81);
        check("halt_load_grid", grid, 64'h81000000_00060600);
        check("halt_load_flags", {stable, extinct}, 2'b10);

        // Load and start on the same edge from HALT.
        load_valid = 1'b1;
        load_row   = 3'd0;
        load_data  = 8'h01;
        start      = 1'b1;
        tick();
        load_valid = 1'b0;
        start      = 1'b0;
        check("ls_grid", grid, 64'h81000000_00060601);
        check("ls_state", state, 2'b10);
        check("ls_flags", {stable, extinct}, 2'b00);
        check("ls_gen", generation, 8'd0);
        pulse_reset();

        // Lone cell dies.
        load(3'd4, 8'h10);
        do_start();
        step();
        check("single_grid", grid, 64'h0);
        check("single_flags", {stable, extinct}, 2'b01);
        check("single_state", state, 2'b11);
        pulse_reset();

        // Border row with wrap.
        wrap_en = 1'b1;
        load(3'd0, 8'h38);
        do_start();
        step();
        check("wrap_grid", grid, 64'h10000000_00001010);
        check("wrap_state", state, 2'b10);
        pulse_reset();

        // Same border row without wrap, then extinction.
        wrap_en = 1'b0;
        load(3'd0, 8'h38);
        do_start();
        step();
        check("nowrap_grid", grid, 64'h00000000_00001010);
        step();
        check("nowrap_s2_grid", grid, 64'h0);
        check("nowrap_s2_flags", {stable, extinct}, 2'b01);
        check("nowrap_s2_state", state, 2'b11);
        check("nowrap_s2_gen", generation, 8'd2);
        pulse_reset();

        // Generation counter saturates on an endless oscillator.
        load(3'd3, 8'h1C);
        do_start();
        for (int i = 0; i < 300; i++) step();
        check("sat_gen", generation, 8'd255);
        check("sat_state", state, 2'b10);
        check("sat_grid", grid, 64'h00000000_1C000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/life_grid_engine.md
LIFE_GRID_ENGINE -- requirements
Module: life_grid_engine

Interface
REQ-001 Parameter GEN_W, default 8, width of the generation counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 load_valid  input  1  seed row write request.
REQ-005 load_ready  output  1  engine accepts a seed row this cycle.
REQ-006 load_row  input  3  row index 0..7 of seed write.
REQ-007 load_data  input  8  seed row; bit c is column c, 1 = alive.
REQ-008 start  input  1  pulse; begin evolving the current grid.
REQ-009 pause  input  1  level; while 1, step_tick is ignored.
REQ-010 step_tick  input  1  one-cycle pulse; advance one generation.
REQ-011 wrap_en  input  1  1 = toroidal edges; 0 = cells beyond the edge are dead.
REQ-012 grid  output  64  cell states; bit 8*r+c is row r, column c.
REQ-013 state  output  2  IDLE=00, RUN=10, HALT=11 (01 unused).
REQ-014 generation  output  GEN_W  generations computed since the last start.
REQ-015 stable  output  1  last step produced a grid identical to its predecessor.
REQ-016 extinct  output  1  last step produced an all-dead grid.

Function
REQ-017 Per cell, the neighbour count SHALL be the 4-bit sum (0..8) of the 8 surrounding cells, with edge handling per wrap_en (indices mod 8 when 1, out-of-range = 0 when 0).
REQ-018 Next state SHALL be: alive if (alive and count in {2,3}) or (dead and count == 3), else dead.
REQ-019 All 64 next states SHALL be computed combinationally from the registered grid; no partial-grid updates.
REQ-020 load_ready SHALL be 1 in IDLE and HALT, 0 in RUN (combinational from state).
REQ-021 On load_valid && load_ready, grid row load_row SHALL take load_data at that edge; other rows unchanged; load_valid in RUN ignored.
REQ-022 IDLE/HALT: start SHALL move to RUN at that edge, clear generation, stable and extinct.
REQ-023 Same-cycle load and start in IDLE/HALT: both take effect at the same edge.
REQ-024 RUN: on step_tick && !pause, grid SHALL take the next state at that edge (latency 1 edge, visible next cycle).
REQ-025 Each step SHALL increment generation, saturating at 2^GEN_W-1.
REQ-026 If the next grid equals the current grid on a step, stable SHALL be set and state SHALL go to HALT at the same edge.
REQ-027 If the next grid is all zero on a step, extinct SHALL be set and state SHALL go to HALT at the same edge; if both conditions hold, both flags are set.
REQ-028 RUN with pause=1 or step_tick=0: grid, generation and flags hold; start in RUN ignored.
REQ-029 HALT SHALL hold the grid and flags until start or reset; loads in HALT do not clear flags.
REQ-030 Unused state encoding 01 SHALL recover to IDLE on the next edge.

Reset
REQ-031 reset_n low SHALL immediately, without a clock edge, force grid=0, state=IDLE, generation=0, stable=0 and extinct=0, giving load_ready=1.
REQ-032 Reset asserted mid-RUN SHALL abort the step in progress; after release the engine waits in IDLE for loads or start.
REQ-033 Inputs sampled during reset SHALL have no effect.

Verification
REQ-034 Blinker: load row 3 = 0x1C, wrap_en=0, start, step -> column 3 rows 2..4 alive (bits 19,27,35), generation=1; second step -> row 3 = 0x1C, generation=2, stable=0.
REQ-035 Block: rows 1,2 = 0x06, start, step -> grid unchanged, stable=1, state=HALT, generation=1.
REQ-036 Single cell (row 4 = 0x10), start, step -> grid=0, extinct=1, state=HALT.
REQ-037 Edge: row 0 = 0x38. With wrap_en=1, step -> column 4 rows 7,0,1 alive. With wrap_en=0, step -> column 4 rows 0,1 alive; next step -> extinct=1.
REQ-038 Pause/reset: in RUN hold pause=1 and pulse step_tick 3 times -> grid and generation unchanged; then pull reset_n low between edges -> outputs reset values immediately.
REQ-039 Load in RUN: load_valid=1, load_row=5, load_data=0xFF -> load_ready=0, row 5 unchanged.
